// File: rtl/mult_34_arbiter.sv
//------------------------------------------------------------------------------
// mult_34_arbiter: shares one mult_34 between two requesters, tag FIFO steers results back in order.
// Optional: MULT_ARB_FIXED_PRIO_EN gives requester 0 fixed priority.   Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mult_34_arbiter #(
   parameter int W_IN  = 17,
   parameter int W_OUT = 34,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W_IN-1:0]  r0_a_tdata,
   input  logic [W_IN-1:0]  r0_b_tdata,
   input  logic             r0_tvalid,
   output logic             r0_tready,
   output logic [W_OUT-1:0] r0_res_tdata,
   output logic             r0_res_tvalid,
   input  logic             r0_res_tready,
   input  logic [W_IN-1:0]  r1_a_tdata,
   input  logic [W_IN-1:0]  r1_b_tdata,
   input  logic             r1_tvalid,
   output logic             r1_tready,
   output logic [W_OUT-1:0] r1_res_tdata,
   output logic             r1_res_tvalid,
   input  logic             r1_res_tready,
   output logic [W_IN-1:0]  m_a_tdata,
   output logic             m_a_tvalid,
   input  logic             m_a_tready,
   output logic [W_IN-1:0]  m_b_tdata,
   output logic             m_b_tvalid,
   input  logic             m_b_tready,
   input  logic [W_OUT-1:0] m_out_tdata,
   input  logic             m_out_tvalid,
   output logic             m_out_tready,
   output logic             orphan_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_ISSUE = 1'b1;

   logic [0:0]      r_state;
   logic            r_last_grant;
   logic [W_IN-1:0] r_op_a;
   logic [W_IN-1:0] r_op_b;
   logic            r_tag;
   logic            r_a_done;
   logic            r_b_done;
   logic [DEPTH-1:0] r_fifo;
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            r_orphan;

   logic w_empty;
   logic w_full;
   logic w_grant;
   logic w_sel;
   logic w_a_hs;
   logic w_b_hs;
   logic w_final;
   logic w_head;
   logic w_head_rdy;
   logic w_pop;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_grant = (r_state == S_IDLE) && !w_full && (r0_tvalid || r1_tvalid);

`ifdef MULT_ARB_FIXED_PRIO_EN
   assign w_sel = !r0_tvalid;
`else
   // Both valid: the requester not served last time wins
   assign w_sel = (r0_tvalid && r1_tvalid) ? !r_last_grant : r1_tvalid;
`endif

   assign w_a_hs  = (r_state == S_ISSUE) && !r_a_done && m_a_tready;
   assign w_b_hs  = (r_state == S_ISSUE) && !r_b_done && m_b_tready;
   assign w_final = (r_state == S_ISSUE) && (r_a_done || w_a_hs) && (r_b_done || w_b_hs);

   assign w_head     = r_fifo[r_rd_ptr];
   assign w_head_rdy = w_head ? r1_res_tready : r0_res_tready;
   assign w_pop      = !w_empty && m_out_tvalid && w_head_rdy;

   assign m_a_tvalid = (r_state == S_ISSUE) && !r_a_done;
   assign m_b_tvalid = (r_state == S_ISSUE) && !r_b_done;
   assign m_a_tdata  = r_op_a;
   assign m_b_tdata  = r_op_b;

   assign r0_tready = w_final && !r_tag;
   assign r1_tready = w_final && r_tag;

   assign r0_res_tvalid = !w_empty && !w_head && m_out_tvalid;
   assign r1_res_tvalid = !w_empty && w_head && m_out_tvalid;
   assign r0_res_tdata  = (!w_empty && !w_head) ? m_out_tdata : '0;
   assign r1_res_tdata  = (!w_empty && w_head) ? m_out_tdata : '0;

   // With no owner on record the multiplier output is drained; held low during reset
   assign m_out_tready = rst ? 1'b0 : (w_empty ? 1'b1 : w_head_rdy);
   assign orphan_err   = r_orphan;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_tag        <= 1'b0;
         r_a_done     <= 1'b0;
         r_b_done     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_op_a   <= w_sel ? r1_a_tdata : r0_a_tdata;
                  r_op_b   <= w_sel ? r1_b_tdata : r0_b_tdata;
                  r_tag    <= w_sel;
                  r_a_done <= 1'b0;
                  r_b_done <= 1'b0;
                  r_state  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (w_a_hs) r_a_done <= 1'b1;
               if (w_b_hs) r_b_done <= 1'b1;
               if (w_final) begin
                  r_last_grant <= r_tag;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fifo   <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_orphan <= 1'b0;
      end else begin
         if (w_final) begin
            r_fifo[r_wr_ptr] <= r_tag;
            r_wr_ptr         <= r_wr_ptr + PW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_final, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_empty && m_out_tvalid) r_orphan <= 1'b1;
      end
   end

endmodule

`default_nettype wire
